// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
// Shared definitions for the 7-segment display sharing logic.
//   disp_state_e   : arbiter FSM state (IDLE, HOLD)
//   NUM_W          : width of the value shown on the display (4 hex digits)
//   SEG_DIGITS     : number of display digits
//   DEF_*_DWELL    : default dwell limits in 25 MHz system clock cycles
// ---------------------------------------------------------------------------
package seg_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } disp_state_e;

    localparam int NUM_W      = 32'd16;
    localparam int SEG_DIGITS = 32'd4;

    localparam int SYS_CLK_HZ    = 32'd25_000_000;
    // 1 s minimum readable time, 3 s before a waiting requester may preempt.
    localparam int DEF_MIN_DWELL = 32'd25_000_000;
    localparam int DEF_MAX_DWELL = 32'd75_000_000;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Returns the first set request
// bit found when searching upward from ptr_i, wrapping past N_REQ-1 to 0.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   idx_o   : chosen index (0 when valid_o is low)
//   valid_o : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]                              req_i,
    input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] ptr_i,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] idx_o,
    output logic                                          valid_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W:0]   sum_s;
    logic [IDX_W:0]   cand_s;
    logic [IDX_W-1:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        sum_s  = '0;
        cand_s = '0;
        idx_s  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum_s  = {1'b0, ptr_i} + (IDX_W+1)'(i);
            cand_s = (sum_s >= (IDX_W+1)'(N_REQ)) ? (sum_s - (IDX_W+1)'(N_REQ)) : sum_s;
            idx_s  = req_i[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : idx_s;
        end
    end

    assign idx_o   = idx_s;
    assign valid_o = |req_i;

endmodule

// File: rtl/seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// seg_disp_arbiter
// Shares one 4-digit hex 7-segment display between N_REQ requesters.
// Round-robin grants; an owner keeps the display for at least MIN_DWELL
// cycles and is preempted after MAX_DWELL cycles if someone else is waiting.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   req_i        : per-requester level request
//   data_flat_i  : requester k value at [16k+15:16k]
//   gnt_o        : one-hot grant (registered)
//   num_out_o    : value for the display scanner num_in (registered)
//   busy_o       : an owner holds the display
//   owner_id_o   : index of current / last owner
// ---------------------------------------------------------------------------
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int               N_REQ     = 4,
    parameter int               MIN_DWELL = DEF_MIN_DWELL,
    parameter int               MAX_DWELL = DEF_MAX_DWELL,
    parameter logic [NUM_W-1:0] IDLE_NUM  = 16'h0000
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [N_REQ-1:0]                              req_i,
    input  logic [NUM_W*N_REQ-1:0]                        data_flat_i,
    output logic [N_REQ-1:0]                              gnt_o,
    output logic [NUM_W-1:0]                              num_out_o,
    output logic                                          busy_o,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner_id_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW_W  = $clog2(MAX_DWELL + 1);

    if ((N_REQ < 2) || (N_REQ > 8) || (MIN_DWELL < 1) || (MAX_DWELL < MIN_DWELL)) begin : g_param_check
        $error("seg_disp_arbiter: illegal N_REQ / MIN_DWELL / MAX_DWELL");
    end

    disp_state_e      state_q,  state_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [NUM_W-1:0] num_q,    num_d;
    logic             busy_q,   busy_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW_W-1:0]  dwell_q,  dwell_d;

    logic [NUM_W-1:0] data_arr_s [N_REQ];
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_valid_s;
    logic             own_req_s;
    logic             others_s;
    logic             release_s;
    logic [IDX_W-1:0] next_ptr_s;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            data_arr_s[k] = data_flat_i[k*NUM_W +: NUM_W];
        end
    end

    // Release decision: voluntary after the minimum dwell, or forced when the
    // maximum dwell is reached and a non-owner is waiting (gnt_q masks owner).
    always_comb begin
        own_req_s  = req_i[owner_q];
        others_s   = |(req_i & ~gnt_q);
        release_s  = (!own_req_s && (dwell_q >= DW_W'(MIN_DWELL - 1))) ||
                     ((dwell_q >= DW_W'(MAX_DWELL - 1)) && others_s);
        next_ptr_s = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : (owner_q + IDX_W'(1));
    end

    // FSM next-state and output-register next values.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        num_d    = num_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE: begin
                num_d = IDLE_NUM;
                if (pick_valid_s) begin
                    state_d = HOLD;
                    gnt_d   = N_REQ'(1) << pick_idx_s;
                    owner_d = pick_idx_s;
                    busy_d  = 1'b1;
                    dwell_d = '0;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            HOLD: begin
                dwell_d = (dwell_q >= DW_W'(MAX_DWELL)) ? dwell_q : (dwell_q + DW_W'(1));
                // Freeze on the last value once the owner lets go of req.
                num_d   = own_req_s ? data_arr_s[owner_q] : num_q;
                if (release_s) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                num_d   = IDLE_NUM;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            num_q    <= IDLE_NUM;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            num_q    <= num_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            dwell_q  <= dwell_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign num_out_o  = num_q;
    assign busy_o     = busy_q;
    assign owner_id_o = owner_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data_flat;
    logic [3:0]  gnt;
    logic [15:0] num_out;
    logic        busy;
    logic [1:0]  owner_id;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] num;
        logic        chk_num;
        logic [1:0]  owner;
        string       tag;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [1:0] exp_owner;

    seg_disp_arbiter #(
        .N_REQ     (4),
        .MIN_DWELL (4),
        .MAX_DWELL (10),
        .IDLE_NUM  (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .data_flat_i (data_flat),
        .gnt_o       (gnt),
        .num_out_o   (num_out),
        .busy_o      (busy),
        .owner_id_o  (owner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input int k, input logic [15:0] v);
        data_flat[k*16 +: 16] = v;
    endtask

    // Push the outputs expected after the coming edge, then advance one cycle.
    task automatic cyc(input logic [3:0] g, input logic [15:0] n, input string tag);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) exp_owner = 2'(i);
        end
        e.gnt     = g;
        e.num     = n;
        e.chk_num = 1'b1;
        e.owner   = exp_owner;
        e.tag     = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk({mon_e.tag, "_gnt"},   32'(gnt),      32'(mon_e.gnt));
            chk({mon_e.tag, "_busy"},  32'(busy),     32'(|mon_e.gnt));
            chk({mon_e.tag, "_owner"}, 32'(owner_id), 32'(mon_e.owner));
            if (mon_e.chk_num) chk({mon_e.tag, "_num"}, 32'(num_out), 32'(mon_e.num));
            chk({mon_e.tag, "_onehot"}, 32'($onehot0(gnt)), 32'(1));
        end
    end

    // Assert reset without waiting for a clock edge, check, then release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_gnt"},   32'(gnt),      32'h0);
        chk({tag, "_rst_busy"},  32'(busy),     32'h0);
        chk({tag, "_rst_num"},   32'(num_out),  32'h0);
        chk({tag, "_rst_owner"}, 32'(owner_id), 32'h0);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        exp_owner = 2'd0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_owner = 2'd0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        data_flat = 64'h0;
        #3;
        chk("t1_gnt",   32'(gnt),      32'h0);
        chk("t1_num",   32'(num_out),  32'h0);
        chk("t1_busy",  32'(busy),     32'h0);
        chk("t1_owner", 32'(owner_id), 32'h0);
        chk("t1_rrptr", 32'(dut.rr_ptr_q), 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Test 2: single request, voluntary release at minimum dwell.
        set_d(1, 16'h1234);
        req = 4'b0010;
        cyc(4'b0010, 16'h0000, "t2_grant");
        cyc(4'b0010, 16'h1234, "t2_first");
        req = 4'b0000;
        set_d(1, 16'hFFFF);
        cyc(4'b0010, 16'h1234, "t2_frz1");
        cyc(4'b0010, 16'h1234, "t2_frz2");
        cyc(4'b0000, 16'h1234, "t2_rel");
        cyc(4'b0000, 16'h0000, "t2_idle");

        // Test 5a: num_out tracks owner data one cycle late; others ignored.
        set_d(0, 16'h0F0F);
        req = 4'b0001;
        cyc(4'b0001, 16'h0000, "t5_grant");
        set_d(0, 16'h1111); set_d(2, 16'hABCD);
        cyc(4'b0001, 16'h1111, "t5_s1");
        set_d(0, 16'h2222); set_d(3, 16'hBEEF);
        cyc(4'b0001, 16'h2222, "t5_s2");
        set_d(0, 16'h3333);
        cyc(4'b0001, 16'h3333, "t5_s3");
        req = 4'b0000;
        set_d(0, 16'h5555);
        cyc(4'b0000, 16'h3333, "t5_rel");
        cyc(4'b0000, 16'h0000, "t5_idle");

        // Test 5b: drop req at dwell 1, value frozen until release at dwell 3.
        set_d(1, 16'h7777);
        req = 4'b0010;
        cyc(4'b0010, 16'h0000, "t5b_grant");
        set_d(1, 16'h3333);
        cyc(4'b0010, 16'h3333, "t5b_load");
        req = 4'b0000;
        set_d(1, 16'h9999);
        cyc(4'b0010, 16'h3333, "t5b_frz1");
        cyc(4'b0010, 16'h3333, "t5b_frz2");
        cyc(4'b0000, 16'h3333, "t5b_rel");
        cyc(4'b0000, 16'h0000, "t5b_idle");

        // Test 1b: asynchronous reset in the middle of HOLD.
        set_d(2, 16'h2A2A);
        req = 4'b0100;
        cyc(4'b0100, 16'h0000, "t1b_grant");
        cyc(4'b0100, 16'h2A2A, "t1b_hold");
        do_reset("t1b");

        // Test 3: all requesting, preemption every 10 cycles in order 0,1,2,3,0.
        data_flat = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            logic [3:0]  g;
            logic [15:0] d;
            g = 4'b0001 << (r % 4);
            d = 16'hD000 + 16'(r % 4);
            cyc(g, 16'h0000, "t3_grant");
            for (int j = 1; j < 10; j++) cyc(g, d, "t3_hold");
            cyc(4'b0000, d, "t3_gap");
        end
        req = 4'b0000;
        cyc(4'b0000, 16'h0000, "t3_idle");

        // Test 4: sole requester never preempted; a newcomer forces release.
        do_reset("t4");
        set_d(0, 16'h4A4A); set_d(2, 16'h4C4C);
        req = 4'b0001;
        cyc(4'b0001, 16'h0000, "t4_grant");
        for (int j = 1; j < 20; j++) cyc(4'b0001, 16'h4A4A, "t4_sole");
        req = 4'b0101;
        cyc(4'b0000, 16'h4A4A, "t4_preempt");
        cyc(4'b0100, 16'h0000, "t4_g2");
        cyc(4'b0100, 16'h4C4C, "t4_d2");

        // Test 6: owner drops and another rises in the same cycle at dwell 3.
        do_reset("t6");
        set_d(0, 16'h6060); set_d(3, 16'h6363);
        req = 4'b0001;
        cyc(4'b0001, 16'h0000, "t6_grant");
        for (int j = 1; j < 4; j++) cyc(4'b0001, 16'h6060, "t6_hold");
        req = 4'b1000;
        cyc(4'b0000, 16'h6060, "t6_rel");
        chk("t6_rrptr_rel", 32'(dut.rr_ptr_q), 32'h1);
        cyc(4'b1000, 16'h0000, "t6_g3");
        cyc(4'b1000, 16'h6363, "t6_d3");
        chk("t6_rrptr_hold", 32'(dut.rr_ptr_q), 32'h1);

        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
